// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and line constants, used by transmitter and receiver.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam logic        IDLE_LEVEL         = 1'b1;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StStart  = ST_START,
    StData   = ST_DATA,
    StParity = ST_PARITY,
    StStop   = ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Counts tick strobes modulo OVERSAMPLE; bit_end_o marks the tick that completes a bit period.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic tick_i,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int unsigned CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] CntMax = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end_o = tick_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = bit_end_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB first, idle-high, with a one-entry holding register for back-to-back frames.
// Define UART_TX_PARITY_EN to append an even parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0] LastBit  = 3'(DATA_BITS - 1);
  localparam logic       LastStop = 1'(STOP_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  logic bit_end;
  logic accept;
  logic start_frame;

  assign accept   = tx_valid && !hold_full_q;
  assign tx_ready = !hold_full_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

  // A frame starts from idle or straight out of the final stop tick when a byte is waiting.
  assign start_frame = tick && hold_full_q &&
                       ((state_q == StIdle) ||
                        ((state_q == StStop) && bit_end && (stop_cnt_q == LastStop)));

  uart_tx_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .tick_i   (tick),
    .clear_i  (start_frame),
    .bit_end_o(bit_end)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    tx_d        = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (start_frame) begin
      state_d     = StStart;
      tx_d        = 1'b0;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      bit_idx_d   = '0;
      stop_cnt_d  = 1'b0;
    end else if (bit_end) begin
      case (state_q)
        StStart: begin
          state_d   = StData;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = shift_q[0];
`endif
        end
        StData: begin
          if (bit_idx_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = IDLE_LEVEL;
`endif
            stop_cnt_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
            parity_d  = parity_q ^ shift_q[0];
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          state_d = StStop;
          tx_d    = IDLE_LEVEL;
        end
`endif
        StStop: begin
          if (stop_cnt_q == LastStop) begin
            state_d = StIdle;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != StIdle) || hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= IDLE_LEVEL;
      busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule
